pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised next-generation program counter for the MIPS core. It owns the PC register and computes PC+4 internally, so there is no external previous-PC input. It arbitrates exception, ERET, stall, JR, J/JAL and conditional-branch redirects, and keeps its own EPC and exception-level state instead of relying on CP0. A small return-address stack (RAS) checks `jr $ra` targets and flags mismatches to the hazard/debug logic.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VEC`, 32'h0000_0800, exception handler entry address.
- `RAS_DEPTH`, 4, number of return-address stack entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  hold the PC (pipeline bubble).
- `HasExp`  in  1  exception taken this cycle.
- `IsEret`  in  1  ERET instruction.
- `IsJR`  in  1  jump register.
- `JrIsRa`  in  1  qualifies `IsJR`: source register is $31.
- `Jump`  in  1  J-type jump.
- `IsJAL`  in  1  qualifies `Jump`: link.
- `Branch`, `Equal`, `BneOrBeq`  in  1 each  branch taken = `Branch & (Equal ^ BneOrBeq)`.
- `op`  in  26  J-type target field.
- `jumpamt`  in  32  sign-extended branch offset, in words.
- `jumpaddr`  in  32  JR target.
- `progaddr`  out  32  current PC.
- `epc`  out  32  PC saved at the last first-level exception.
- `exc_level`  out  1  1 while inside the handler.
- `ras_top`  out  32  RAS top entry; 0 when the RAS is empty.
- `ras_miss`  out  1  registered one-cycle pulse on a RAS mispredict.

## Operation
- `pc4 = progaddr + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- The next PC comes from the first matching rule, highest priority first:
  1. `HasExp` → `EXC_VEC`.
  2. `IsEret & exc_level` → `epc`.
  3. `stall` → `progaddr` (hold).
  4. `IsJR` → `jumpaddr`.
  5. `Jump` → `{pc4[31:28], op, 2'b00}`.
  6. Branch taken → `pc4 + (jumpamt << 2)`, modulo 2^32.
  7. Otherwise → `pc4`.
- `IsEret` with `exc_level=0` is ignored and falls through to the lower-priority rules.
- Exception handling:
  - With `exc_level=0`: `epc <= progaddr` and `exc_level <= 1`.
  - With `exc_level=1` (nested): vector to `EXC_VEC` but leave `epc` unchanged.
  - An ERET that is taken clears `exc_level`.
- RAS update, applied only in cycles where rules 1–3 do not apply:
  - Push on `Jump & IsJAL`: write `pc4`. When full, overwrite the oldest entry circularly; the count saturates at `RAS_DEPTH`.
  - Pop on `IsJR & JrIsRa`. `ras_miss <= 1` if the RAS is empty or `ras_top != jumpaddr`; the count decrements but not below 0.
  - Push and pop in the same cycle: the pop happens first, then the push, so the top is replaced and the count is unchanged.
- `HasExp`, ERET and `stall` suppress all RAS updates, and `ras_miss` is 0 in those cycles.
- Reset values: `progaddr=RESET_VEC`, `epc=0`, `exc_level=0`, RAS count 0, `ras_top=0`, `ras_miss=0`.

## Timing
- All state updates on the rising edge of `clk`. The next-PC logic is combinational from the inputs and current state, so the redirect has 1-cycle latency.
- `ras_miss` is asserted in the cycle after the JR is sampled and lasts exactly one cycle.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately, with no clock edge needed. The first update after release occurs on the first rising edge with `reset=0`.
- `stall` held for N cycles → `progaddr` held for N cycles, then it resumes with whatever inputs are present on the release edge.

## Structure
- Package `pc_pkg`:
  - Constants `PC_W=32`, `DEF_RESET_VEC`, `DEF_EXC_VEC`.
  - Enum `next_src_t` with values {EXC, ERET, HOLD, JR, J, BR, SEQ} for the next-PC select; the bench uses it for coverage.
- Sub-module `ras_stack #(DEPTH)`:
  - Inputs: `push`, `pop`, `wdata`.
  - Outputs: `top`, `empty`, `full`.
  - Circular pointer plus saturating count.
- The top level holds the priority mux, PC/EPC/EXL registers and the mispredict compare.

## Test plan
- Reset, release, then 3 unstalled cycles → `progaddr` reads 0x0, 0x4, 0x8, 0xC; `stall` for 2 cycles → holds 0xC.
- At PC=0x10: `Branch=1`, `Equal=1`, `BneOrBeq=0`, `jumpamt=4` → next PC 0x24. The same stimulus with `BneOrBeq=1` → 0x14.
- At PC=0x24: `Jump=1`, `op=26'h400` → 0x1000. At 0x1000: `Jump=1`, `IsJAL=1`, `op=26'h800` → PC 0x2000 and `ras_top=0x1004`.
- At 0x2000: `IsJR=1`, `JrIsRa=1`, `jumpaddr=0x1004` → PC 0x1004, `ras_miss=0`. Repeat the JAL, then JR with `jumpaddr=0x3000` → PC 0x3000, `ras_miss` pulses 1 cycle. Pop on empty → `ras_miss=1`. 6 pushes with `RAS_DEPTH=4` → the last 4 return addresses pop in LIFO order.
- At PC=0x3000: `HasExp=1` together with `Jump=1` → PC 0x800, `epc=0x3000`, `exc_level=1`, RAS unchanged. A nested `HasExp` → PC 0x800, `epc` still 0x3000. Then `IsEret=1` → PC 0x3000, `exc_level=0`. A further `IsEret` with `exc_level=0` → PC+4.
- At PC=32'hFFFF_FFFC with no control inputs → PC 0. Assert `reset` between edges → `progaddr=RESET_VEC` before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source encoding for the
// program-counter sequencer.
package pc_pkg;

   localparam int PC_W = 32;

   localparam logic [PC_W-1:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [PC_W-1:0] DEF_EXC_VEC   = 32'h0000_0800;

   typedef enum logic [2:0] {
      EXC,
      ERET,
      HOLD,
      JR,
      J,
      BR,
      SEQ
   } next_src_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular pointer with a saturating count,
// so a push when full silently overwrites the oldest entry.
module ras_stack
   import pc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = PC_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] ptr_q, ptr_d, ptr_pop;
   logic [CW-1:0] cnt_q, cnt_d, cnt_pop;

   // pop is resolved first so push+pop replaces the top in place
   always_comb begin
      ptr_pop = ptr_q;
      cnt_pop = cnt_q;
      if (pop && cnt_q != '0) begin
         ptr_pop = ptr_q - AW'(1);
         cnt_pop = cnt_q - CW'(1);
      end
      ptr_d = ptr_pop;
      cnt_d = cnt_pop;
      if (push) begin
         ptr_d = ptr_pop + AW'(1);
         if (cnt_pop != CW'(DEPTH))
            cnt_d = cnt_pop + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (push)
            mem_q[ptr_d] <= wdata;
      end
   end

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign top   = empty ? '0 : mem_q[ptr_q];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with prioritised redirects, private EPC/EXL state
// and a return-address stack that checks jr $ra targets.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [PC_W-1:0] EXC_VEC   = DEF_EXC_VEC,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            HasExp,
   input  logic            IsEret,
   input  logic            IsJR,
   input  logic            JrIsRa,
   input  logic            Jump,
   input  logic            IsJAL,
   input  logic            Branch,
   input  logic            Equal,
   input  logic            BneOrBeq,
   input  logic [25:0]     op,
   input  logic [PC_W-1:0] jumpamt,
   input  logic [PC_W-1:0] jumpaddr,
   output logic [PC_W-1:0] progaddr,
   output logic [PC_W-1:0] epc,
   output logic            exc_level,
   output logic [PC_W-1:0] ras_top,
   output logic            ras_miss
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            exl_q, exl_d;
   logic            miss_q, miss_d;

   logic [PC_W-1:0] pc4, br_tgt;
   logic            br_taken, eret_take;
   logic            ras_en, ras_push, ras_pop;
   logic            ras_empty, ras_full;
   next_src_t       sel;

   assign pc4       = pc_q + 32'd4;
   assign br_tgt    = pc4 + (jumpamt << 2);
   assign br_taken  = Branch & (Equal ^ BneOrBeq);
   assign eret_take = IsEret & exl_q;

   always_comb begin
      sel = SEQ;
      priority case (1'b1)
         HasExp:    sel = EXC;
         eret_take: sel = ERET;
         stall:     sel = HOLD;
         IsJR:      sel = JR;
         Jump:      sel = J;
         br_taken:  sel = BR;
         default:   sel = SEQ;
      endcase
   end

   always_comb begin
      pc_d = pc4;
      unique case (sel)
         EXC:     pc_d = EXC_VEC;
         ERET:    pc_d = epc_q;
         HOLD:    pc_d = pc_q;
         JR:      pc_d = jumpaddr;
         J:       pc_d = {pc4[31:28], op, 2'b00};
         BR:      pc_d = br_tgt;
         default: pc_d = pc4;
      endcase
   end

   // nested exceptions keep the original return point
   always_comb begin
      epc_d = epc_q;
      exl_d = exl_q;
      if (HasExp) begin
         exl_d = 1'b1;
         if (!exl_q)
            epc_d = pc_q;
      end else if (eret_take) begin
         exl_d = 1'b0;
      end
   end

   assign ras_en   = (sel != EXC) && (sel != ERET) && (sel != HOLD);
   assign ras_push = ras_en & Jump & IsJAL;
   assign ras_pop  = ras_en & IsJR & JrIsRa;
   assign miss_d   = ras_pop & (ras_empty | (ras_top != jumpaddr));

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .wdata (pc4),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_VEC;
         epc_q  <= '0;
         exl_q  <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         epc_q  <= epc_d;
         exl_q  <= exl_d;
         miss_q <= miss_d;
      end
   end

   assign progaddr  = pc_q;
   assign epc       = epc_q;
   assign exc_level = exl_q;
   assign ras_miss  = miss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed
// expected PCs, EPC, exception level and RAS behaviour.
module tb_pc_sequencer;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, HasExp, IsEret, IsJR, JrIsRa;
   logic        Jump, IsJAL, Branch, Equal, BneOrBeq;
   logic [25:0] op;
   logic [31:0] jumpamt, jumpaddr;
   logic [31:0] progaddr, epc, ras_top;
   logic        exc_level, ras_miss;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] ret_exp [4];

   pc_sequencer #(
      .RESET_VEC (32'h0000_0000),
      .EXC_VEC   (32'h0000_0800),
      .RAS_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .HasExp    (HasExp),
      .IsEret    (IsEret),
      .IsJR      (IsJR),
      .JrIsRa    (JrIsRa),
      .Jump      (Jump),
      .IsJAL     (IsJAL),
      .Branch    (Branch),
      .Equal     (Equal),
      .BneOrBeq  (BneOrBeq),
      .op        (op),
      .jumpamt   (jumpamt),
      .jumpaddr  (jumpaddr),
      .progaddr  (progaddr),
      .epc       (epc),
      .exc_level (exc_level),
      .ras_top   (ras_top),
      .ras_miss  (ras_miss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      stall = 0; HasExp = 0; IsEret = 0; IsJR = 0; JrIsRa = 0;
      Jump = 0; IsJAL = 0; Branch = 0; Equal = 0; BneOrBeq = 0;
      op = '0; jumpamt = '0; jumpaddr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic jal(input logic [25:0] t);
      clr(); Jump = 1; IsJAL = 1; op = t;
      step();
   endtask

   task automatic jra(input logic [31:0] a);
      clr(); IsJR = 1; JrIsRa = 1; jumpaddr = a;
      step();
   endtask

   initial begin
      ret_exp[0] = 32'h5004;
      ret_exp[1] = 32'h4C04;
      ret_exp[2] = 32'h4804;
      ret_exp[3] = 32'h4404;

      clr();
      reset = 1;
      #2;
      chk("rst_pc", progaddr, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_exl", {31'b0, exc_level}, 32'h0);
      chk("rst_top", ras_top, 32'h0);
      chk("rst_miss", {31'b0, ras_miss}, 32'h0);

      step();
      reset = 0;
      chk("rel_pc", progaddr, 32'h0);
      step(); chk("seq_4", progaddr, 32'h4);
      step(); chk("seq_8", progaddr, 32'h8);
      step(); chk("seq_c", progaddr, 32'hC);
      stall = 1;
      step(); chk("stall1", progaddr, 32'hC);
      step(); chk("stall2", progaddr, 32'hC);
      stall = 0;
      step(); chk("seq_10", progaddr, 32'h10);

      Branch = 1; Equal = 1; jumpamt = 32'd4;
      step(); chk("beq_tk", progaddr, 32'h24);
      BneOrBeq = 1;
      step(); chk("beq_nt", progaddr, 32'h28);
      clr(); Branch = 1; BneOrBeq = 1; jumpamt = 32'hFFFF_FFFE;
      step(); chk("bne_back", progaddr, 32'h24);

      clr(); Jump = 1; op = 26'h400;
      step(); chk("j", progaddr, 32'h1000);
      jal(26'h800);
      chk("jal_pc", progaddr, 32'h2000);
      chk("jal_top", ras_top, 32'h1004);
      jra(32'h1004);
      chk("jr_ok_pc", progaddr, 32'h1004);
      chk("jr_ok_miss", {31'b0, ras_miss}, 32'h0);
      chk("jr_ok_top", ras_top, 32'h0);

      jal(26'h800);
      chk("jal2_top", ras_top, 32'h1008);
      jra(32'h3000);
      chk("jr_bad_pc", progaddr, 32'h3000);
      chk("jr_bad_miss", {31'b0, ras_miss}, 32'h1);
      clr();
      step();
      chk("miss_pulse", {31'b0, ras_miss}, 32'h0);
      chk("seq_3004", progaddr, 32'h3004);
      jra(32'h3000);
      chk("jr_empty", {31'b0, ras_miss}, 32'h1);

      // six calls: 0x3000 -> 0x4000, 0x4400, ... 0x5400
      for (int i = 0; i < 6; i++)
         jal(26'h1000 + 26'(i * 32'h100));
      chk("calls_pc", progaddr, 32'h5400);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lifo_top%0d", i), ras_top, ret_exp[i]);
         jra(ret_exp[i]);
         chk($sformatf("lifo_miss%0d", i), {31'b0, ras_miss}, 32'h0);
      end
      jra(32'h2FF0);
      chk("drained", {31'b0, ras_miss}, 32'h1);

      jal(26'hC00);
      chk("pre_exc_pc", progaddr, 32'h3000);
      chk("pre_exc_top", ras_top, 32'h2FF4);
      clr(); HasExp = 1; Jump = 1; IsJAL = 1; op = 26'h10;
      step();
      chk("exc_pc", progaddr, 32'h800);
      chk("exc_epc", epc, 32'h3000);
      chk("exc_exl", {31'b0, exc_level}, 32'h1);
      chk("exc_top", ras_top, 32'h2FF4);
      chk("exc_miss", {31'b0, ras_miss}, 32'h0);
      clr(); HasExp = 1;
      step();
      chk("nest_pc", progaddr, 32'h800);
      chk("nest_epc", epc, 32'h3000);
      clr(); IsEret = 1; IsJR = 1; JrIsRa = 1; jumpaddr = 32'h2FF4;
      step();
      chk("eret_pc", progaddr, 32'h3000);
      chk("eret_exl", {31'b0, exc_level}, 32'h0);
      chk("eret_top", ras_top, 32'h2FF4);
      chk("eret_miss", {31'b0, ras_miss}, 32'h0);
      clr(); IsEret = 1;
      step();
      chk("eret_off", progaddr, 32'h3004);

      clr(); IsJR = 1; jumpaddr = 32'hFFFF_FFFC;
      step();
      chk("jr_top_pc", progaddr, 32'hFFFF_FFFC);
      clr();
      step();
      chk("wrap", progaddr, 32'h0);
      step();
      HasExp = 1;
      step();
      chk("exc2_epc", epc, 32'h4);
      clr();
      @(negedge clk);
      reset = 1;
      #1;
      chk("arst_pc", progaddr, 32'h0);
      chk("arst_epc", epc, 32'h0);
      chk("arst_exl", {31'b0, exc_level}, 32'h0);
      chk("arst_top", ras_top, 32'h0);
      @(negedge clk);
      reset = 0;
      step();
      chk("post_rst", progaddr, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
